// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS main control unit: state
// encodings, opcodes, ALU / mux select codes and the packed strobe bundle.
package mips_ctrl_pkg;

  // Debug-visible state encodings; unlisted codes fall back to FETCH.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_t;

  // Supported opcodes (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // alu_op codes consumed by alu_control.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-input select.
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Width of the memory wait counter.
  localparam int unsigned WAIT_CNT_W = 4;

  // All per-cycle datapath strobes, built as one word so a single default
  // clears every field.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_err;
  } ctrl_t;

  // DECODE dispatch; FETCH doubles as the "unsupported opcode" answer.
  function automatic state_t decode_target(input logic [5:0] op);
    case (op)
      OP_RTYPE:     return S_EXEC;
      OP_LW, OP_SW: return S_MEM_ADDR;
      OP_BEQ:       return S_BRANCH;
      OP_J:         return S_JUMP;
      OP_ADDI:      return S_ADDI_EX;
      default:      return S_FETCH;
    endcase
  endfunction

  // States that wait on the memory handshake and are subject to timeout.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the main control FSM (master) and the shared
// datapath (slave): decoded instruction/status in, strobes and debug state out.
interface mc_control_fsm_if;

  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic       mem_err;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, mem_err, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, mem_err, state
  );

endinterface

// File: rtl/mc_control_fsm_mem_wait_timer.sv
// Counts consecutive stalled cycles in a memory-wait state and flags the
// cycle in which the wait would reach LIMIT. The count restarts whenever
// the FSM leaves the state (ready, not waiting, or the timeout itself).
// LIMIT must lie in 1..2**WAIT_CNT_W.
module mem_wait_timer
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic ready,
  output logic expired
);

  logic [WAIT_CNT_W-1:0] count;
  logic                  stalled;

  assign stalled = waiting && !ready;
  // count holds the stalled cycles already spent, so the LIMIT-th stalled
  // cycle sees LIMIT-1; a ready in that same cycle wins.
  assign expired = stalled && (count == WAIT_CNT_W'(LIMIT - 1));

  // Stall counter: advance while stalled, otherwise restart.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge (synchronous), so it sits
    // inside the clocked block and is absent from the sensitivity list.
    if (!rst_n) begin
      count <= '0;
    end else if (stalled && !expired) begin
      count <= count + WAIT_CNT_W'(1);
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle main control unit: sequences fetch/decode/execute/memory/
// writeback over the shared datapath, stalls on mem_ready, times out stuck
// memory accesses and flags unsupported opcodes.
module mc_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  mc_control_fsm_if.master  bus
);

  state_t state_q;
  logic   waiting;
  logic   timeout;
  ctrl_t  ctrl;
  ctrl_t  ctrl_out;

  // The branch condition is resolved in the datapath via pc_write_cond;
  // the sequencer itself never needs zero.
  logic unused_zero;
  assign unused_zero = bus.zero;

  assign waiting = is_wait_state(state_q);

  mem_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .waiting (waiting),
    .ready   (bus.mem_ready),
    .expired (timeout)
  );

  // State register and transitions; a timeout abandons the access to FETCH.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state, so every
    // flop in the design samples pre-edge values regardless of block order.
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (bus.mem_ready)  state_q <= S_DECODE;
          else if (timeout)   state_q <= S_FETCH;
        end
        S_DECODE:   state_q <= decode_target(bus.opcode);
        S_MEM_ADDR: state_q <= (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: begin
          if (bus.mem_ready)  state_q <= S_MEM_WB;
          else if (timeout)   state_q <= S_FETCH;
        end
        S_MEM_WR: begin
          if (bus.mem_ready || timeout) state_q <= S_FETCH;
        end
        S_EXEC:     state_q <= S_R_WB;
        S_ADDI_EX:  state_q <= S_ADDI_WB;
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  // Moore strobe decode; FETCH gates pc_write/ir_write with mem_ready.
  always_comb begin
    // NOTE: assign the whole bundle a default first so no path through the
    // case leaves a field unassigned and infers a latch.
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = bus.mem_ready;
        ctrl.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH2;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = (decode_target(bus.opcode) == S_FETCH);
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ;
    endcase
    // timeout only fires on a stalled cycle, where the request strobe is
    // the only one active, so nothing else needs suppressing here.
    ctrl.mem_err = timeout;
  end

  // Everything reads zero while reset is held, including the debug state.
  assign ctrl_out = rst_n ? ctrl : '0;

  assign bus.pc_write      = ctrl_out.pc_write;
  assign bus.pc_write_cond = ctrl_out.pc_write_cond;
  assign bus.i_or_d        = ctrl_out.i_or_d;
  assign bus.mem_read      = ctrl_out.mem_read;
  assign bus.mem_write     = ctrl_out.mem_write;
  assign bus.ir_write      = ctrl_out.ir_write;
  assign bus.mem_to_reg    = ctrl_out.mem_to_reg;
  assign bus.reg_dst       = ctrl_out.reg_dst;
  assign bus.reg_write     = ctrl_out.reg_write;
  assign bus.alu_src_a     = ctrl_out.alu_src_a;
  assign bus.alu_src_b     = ctrl_out.alu_src_b;
  assign bus.alu_op        = ctrl_out.alu_op;
  assign bus.pc_source     = ctrl_out.pc_source;
  assign bus.illegal_op    = ctrl_out.illegal_op;
  assign bus.mem_err       = ctrl_out.mem_err;
  assign bus.state         = rst_n ? 4'(state_q) : 4'd0;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: each cycle the driver sets the
// inputs and pushes the expected state/strobe word; a negedge monitor pops
// and compares it against the DUT.
module tb_mc_control_fsm;

  localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1, ST_MEM_ADDR = 4'd2,
                         ST_MEM_RD = 4'd3, ST_MEM_WB = 4'd4, ST_MEM_WR = 4'd5,
                         ST_EXEC = 4'd6,   ST_R_WB = 4'd7,   ST_BRANCH = 4'd8,
                         ST_JUMP = 4'd9,   ST_ADDI_EX = 4'd10, ST_ADDI_WB = 4'd11;

  localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011,
                         O_BEQ = 6'b000100, O_J = 6'b000010, O_ADDI = 6'b001000;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_err;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  exp;
  } sb_item_t;

  logic     clk = 1'b0;
  logic     rst_n;
  sb_item_t sb[$];
  int       checks = 0;
  int       errors = 0;
  int       step_no = 0;
  string    phase = "init";

  mc_control_fsm_if bus();

  mc_control_fsm #(
    .MEM_TIMEOUT (15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Expected outputs for one cycle, written from the control table.
  function automatic obs_t model(input logic [3:0] st, input logic [5:0] op,
                                 input logic rdy, input logic err);
    obs_t o;
    o = '0;
    o.state = st;
    case (st)
      ST_FETCH:    begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
      ST_DECODE:   begin
        o.alu_src_b  = 2'b11;
        o.illegal_op = !(op == O_R || op == O_LW || op == O_SW ||
                         op == O_BEQ || op == O_J || op == O_ADDI);
      end
      ST_MEM_ADDR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      ST_MEM_RD:   begin o.mem_read = 1; o.i_or_d = 1; end
      ST_MEM_WB:   begin o.reg_write = 1; o.mem_to_reg = 1; end
      ST_MEM_WR:   begin o.mem_write = 1; o.i_or_d = 1; end
      ST_EXEC:     begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      ST_R_WB:     begin o.reg_write = 1; o.reg_dst = 1; end
      ST_BRANCH:   begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_source = 2'b01; end
      ST_JUMP:     begin o.pc_write = 1; o.pc_source = 2'b10; end
      ST_ADDI_EX:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      ST_ADDI_WB:  begin o.reg_write = 1; end
      default: ;
    endcase
    o.mem_err = err;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.state         = bus.state;
    o.pc_write      = bus.pc_write;
    o.pc_write_cond = bus.pc_write_cond;
    o.i_or_d        = bus.i_or_d;
    o.mem_read      = bus.mem_read;
    o.mem_write     = bus.mem_write;
    o.ir_write      = bus.ir_write;
    o.mem_to_reg    = bus.mem_to_reg;
    o.reg_dst       = bus.reg_dst;
    o.reg_write     = bus.reg_write;
    o.alu_src_a     = bus.alu_src_a;
    o.alu_src_b     = bus.alu_src_b;
    o.alu_op        = bus.alu_op;
    o.pc_source     = bus.pc_source;
    o.illegal_op    = bus.illegal_op;
    o.mem_err       = bus.mem_err;
    return o;
  endfunction

  task automatic set_phase(input string name);
    phase   = name;
    step_no = 0;
  endtask

  // One clock cycle: drive inputs, push the expectation, advance.
  task automatic cyc(input logic rst, input logic [5:0] op, input logic rdy,
                     input logic z, input logic [3:0] st, input logic err);
    sb_item_t it;
    rst_n         = rst;
    bus.opcode    = op;
    bus.mem_ready = rdy;
    bus.zero      = z;
    it.tag = $sformatf("%s[%0d]", phase, step_no);
    it.exp = rst ? model(st, op, rdy, err) : obs_t'('0);
    step_no++;
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, half a cycle away from the active edge.
  always @(negedge clk) begin
    sb_item_t it;
    if (sb.size() > 0) begin
      it = sb.pop_front();
      check(it.tag, {10'd0, sample()}, {10'd0, it.exp});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.opcode    = '0;
    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;
    @(posedge clk);
    #1;

    set_phase("reset");
    cyc(0, O_R, 1, 0, ST_FETCH, 0);
    cyc(0, O_R, 1, 0, ST_FETCH, 0);

    // R-type, mem_ready toggled in non-wait states to show it is ignored.
    set_phase("rtype");
    cyc(1, O_R, 1, 0, ST_FETCH, 0);
    cyc(1, O_R, 0, 0, ST_DECODE, 0);
    cyc(1, O_R, 1, 0, ST_EXEC, 0);
    cyc(1, O_R, 0, 0, ST_R_WB, 0);

    // Reset for 3 cycles in EXEC, then a stalled FETCH and a full R-type.
    set_phase("rst_mid");
    cyc(1, O_R, 1, 0, ST_FETCH, 0);
    cyc(1, O_R, 1, 0, ST_DECODE, 0);
    cyc(1, O_R, 1, 0, ST_EXEC, 0);
    for (int i = 0; i < 3; i++) cyc(0, O_R, 1, 0, ST_FETCH, 0);
    cyc(1, O_R, 0, 0, ST_FETCH, 0);
    cyc(1, O_R, 1, 0, ST_FETCH, 0);
    cyc(1, O_R, 1, 0, ST_DECODE, 0);
    cyc(1, O_R, 1, 0, ST_EXEC, 0);
    cyc(1, O_R, 1, 0, ST_R_WB, 0);

    set_phase("lw_wait3");
    cyc(1, O_LW, 1, 0, ST_FETCH, 0);
    cyc(1, O_LW, 1, 0, ST_DECODE, 0);
    cyc(1, O_LW, 0, 0, ST_MEM_ADDR, 0);
    for (int i = 0; i < 3; i++) cyc(1, O_LW, 0, 0, ST_MEM_RD, 0);
    cyc(1, O_LW, 1, 0, ST_MEM_RD, 0);
    cyc(1, O_LW, 1, 0, ST_MEM_WB, 0);

    set_phase("sw");
    cyc(1, O_SW, 1, 0, ST_FETCH, 0);
    cyc(1, O_SW, 1, 0, ST_DECODE, 0);
    cyc(1, O_SW, 1, 0, ST_MEM_ADDR, 0);
    cyc(1, O_SW, 1, 0, ST_MEM_WR, 0);

    set_phase("beq_z1");
    cyc(1, O_BEQ, 1, 1, ST_FETCH, 0);
    cyc(1, O_BEQ, 1, 1, ST_DECODE, 0);
    cyc(1, O_BEQ, 1, 1, ST_BRANCH, 0);
    set_phase("beq_z0");
    cyc(1, O_BEQ, 1, 0, ST_FETCH, 0);
    cyc(1, O_BEQ, 1, 0, ST_DECODE, 0);
    cyc(1, O_BEQ, 1, 0, ST_BRANCH, 0);

    set_phase("j");
    cyc(1, O_J, 1, 0, ST_FETCH, 0);
    cyc(1, O_J, 1, 0, ST_DECODE, 0);
    cyc(1, O_J, 1, 0, ST_JUMP, 0);

    set_phase("addi");
    cyc(1, O_ADDI, 1, 0, ST_FETCH, 0);
    cyc(1, O_ADDI, 1, 0, ST_DECODE, 0);
    cyc(1, O_ADDI, 1, 0, ST_ADDI_EX, 0);
    cyc(1, O_ADDI, 1, 0, ST_ADDI_WB, 0);

    set_phase("illegal");
    cyc(1, 6'b111111, 1, 0, ST_FETCH, 0);
    cyc(1, 6'b111111, 1, 0, ST_DECODE, 0);
    cyc(1, 6'b000001, 1, 0, ST_FETCH, 0);
    cyc(1, 6'b000001, 1, 0, ST_DECODE, 0);

    // sw with mem_ready stuck low: error on the 15th waiting cycle.
    set_phase("sw_timeout");
    cyc(1, O_SW, 1, 0, ST_FETCH, 0);
    cyc(1, O_SW, 1, 0, ST_DECODE, 0);
    cyc(1, O_SW, 1, 0, ST_MEM_ADDR, 0);
    for (int i = 0; i < 14; i++) cyc(1, O_SW, 0, 0, ST_MEM_WR, 0);
    cyc(1, O_SW, 0, 0, ST_MEM_WR, 1);
    cyc(1, O_SW, 0, 0, ST_FETCH, 0);

    // Ready arriving on the 15th cycle wins over the timeout.
    set_phase("sw_ready15");
    cyc(1, O_SW, 1, 0, ST_FETCH, 0);
    cyc(1, O_SW, 1, 0, ST_DECODE, 0);
    cyc(1, O_SW, 1, 0, ST_MEM_ADDR, 0);
    for (int i = 0; i < 14; i++) cyc(1, O_SW, 0, 0, ST_MEM_WR, 0);
    cyc(1, O_SW, 1, 0, ST_MEM_WR, 0);

    set_phase("lw_timeout");
    cyc(1, O_LW, 1, 0, ST_FETCH, 0);
    cyc(1, O_LW, 1, 0, ST_DECODE, 0);
    cyc(1, O_LW, 1, 0, ST_MEM_ADDR, 0);
    for (int i = 0; i < 14; i++) cyc(1, O_LW, 0, 0, ST_MEM_RD, 0);
    cyc(1, O_LW, 0, 0, ST_MEM_RD, 1);

    // Instruction fetch timing out stays in FETCH with a fresh count.
    set_phase("fetch_timeout");
    for (int i = 0; i < 14; i++) cyc(1, O_R, 0, 0, ST_FETCH, 0);
    cyc(1, O_R, 0, 0, ST_FETCH, 1);
    for (int i = 0; i < 3; i++) cyc(1, O_R, 0, 0, ST_FETCH, 0);
    cyc(1, O_R, 1, 0, ST_FETCH, 0);
    cyc(1, O_R, 1, 0, ST_DECODE, 0);
    cyc(1, O_R, 1, 0, ST_EXEC, 0);
    cyc(1, O_R, 1, 0, ST_R_WB, 0);
    cyc(1, O_R, 0, 0, ST_FETCH, 0);

    @(negedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
